// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus bridge and its region decoder.
//   - default address/data widths and the read-data pattern returned on error
//   - bridge state encoding (IDLE / REQ / DONE)
//   - region_decode(): address -> one-hot channel select + hit flag, with
//     priority to the lowest channel index when regions overlap
// No ports (package).
package mem_bus_pkg;

    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // Upper bounds the decode function is written against; callers
    // zero-extend their narrower vectors into these widths.
    localparam int MAX_CH = 8;
    localparam int MAX_AW = 64;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic              hit;
        logic [MAX_CH-1:0] sel;
    } decode_t;

    // Slice i of base/mask describes channel i. Only the first nch slices
    // take part; the first matching slice wins.
    function automatic decode_t region_decode(
        input logic [MAX_AW-1:0]        addr,
        input logic [MAX_CH*MAX_AW-1:0] base,
        input logic [MAX_CH*MAX_AW-1:0] mask,
        input int                       nch
    );
        decode_t r;
        r = '0;
        for (int i = 0; i < MAX_CH; i++) begin
            if ((i < nch) && !r.hit &&
                ((addr & mask[i*MAX_AW +: MAX_AW]) == base[i*MAX_AW +: MAX_AW])) begin
                r.hit    = 1'b1;
                r.sel[i] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_bus_bridge_if.sv
// Slave-side bus of the memory bridge: a valid/ready request channel with
// a one-hot channel select.
//   valid  request valid              we     write strobe
//   addr   address                    wdata  write data
//   sel    one-hot channel select     ready  slave accepts/completes
//   rdata  read data, sampled when valid && ready
// Modports: master (bridge side), slave (memory/peripheral side).
interface mem_bus_bridge_if
    import mem_bus_pkg::*;
#(
    parameter int AW  = DEF_AW,
    parameter int DW  = DEF_DW,
    parameter int NCH = 2
);
    logic           valid;
    logic           we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [NCH-1:0] sel;
    logic           ready;
    logic [DW-1:0]  rdata;

    modport master (
        output valid, we, addr, wdata, sel,
        input  ready, rdata
    );

    modport slave (
        input  valid, we, addr, wdata, sel,
        output ready, rdata
    );

endinterface

// File: rtl/mem_bus_decode.sv
// Combinational NCH-way address region decoder.
//   addr  in   AW   address to decode
//   sel   out  NCH  one-hot channel select (all zero when nothing hits)
//   hit   out  1    some channel claims the address
// Channel i hits when (addr & REGION_MASK[i]) == REGION_BASE[i]; the lowest
// matching index wins. Shared with the instruction-fetch side.
module mem_bus_decode
    import mem_bus_pkg::*;
#(
    parameter int                  AW          = DEF_AW,
    parameter int                  NCH         = 2,
    parameter logic [NCH*AW-1:0]   REGION_BASE = '0,
    parameter logic [NCH*AW-1:0]   REGION_MASK = '0
) (
    input  logic [AW-1:0]  addr,
    output logic [NCH-1:0] sel,
    output logic           hit
);

    logic [MAX_CH*MAX_AW-1:0] base_w;
    logic [MAX_CH*MAX_AW-1:0] mask_w;
    decode_t                  dec;
    logic                     unused_dec;

    // Re-pack the region tables into the fixed slice width the shared
    // decode function expects.
    always_comb begin
        base_w = '0;
        mask_w = '0;
        for (int i = 0; i < NCH; i++) begin
            base_w[i*MAX_AW +: MAX_AW] = MAX_AW'(REGION_BASE[i*AW +: AW]);
            mask_w[i*MAX_AW +: MAX_AW] = MAX_AW'(REGION_MASK[i*AW +: AW]);
        end
    end

    assign dec = region_decode(MAX_AW'(addr), base_w, mask_w, NCH);
    assign sel = dec.sel[NCH-1:0];
    assign hit = dec.hit;

    // Select bits above NCH are always zero.
    assign unused_dec = ^dec.sel;

endmodule

// File: rtl/mem_bus_bridge.sv
// Bridge from the core's zero-wait data-memory port to a valid/ready bus
// with wait states, NCH-way address decode and a request timeout.
//   clk, rst     clock, synchronous active-high reset
//   core_req     load/store active          core_we     1=store, 0=load
//   core_addr    access address             core_wdata  store data
//   core_rdata   load data (valid when core_stall=0 and core_req=1)
//   core_stall   freeze PC / register-file write
//   core_err     one-cycle pulse: access ended in error
//   bus          mem_bus_bridge_if.master (valid/we/addr/wdata/sel/ready/rdata)
// Optional build macro MEM_BUS_BRIDGE_POSTED_WRITE_EN: stores are posted
// into a single-entry buffer and retire without stalling the core.
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter int                AW          = DEF_AW,
    parameter int                DW          = DEF_DW,
    parameter int                NCH         = 2,
    parameter logic [NCH*AW-1:0] REGION_BASE = {32'h0000_1000, 32'h0000_0000},
    parameter logic [NCH*AW-1:0] REGION_MASK = {32'hFFFF_F000, 32'hFFFF_F000},
    parameter int                TIMEOUT     = 16,
    parameter logic [DW-1:0]     ERR_DATA    = DW'(ERR_DATA_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [AW-1:0]     core_addr,
    input  logic [DW-1:0]     core_wdata,
    output logic [DW-1:0]     core_rdata,
    output logic              core_stall,
    output logic              core_err,
    mem_bus_bridge_if.master  bus
);

    localparam logic [1:0] ST_IDLE = S_IDLE;
    localparam logic [1:0] ST_REQ  = S_REQ;
    localparam logic [1:0] ST_DONE = S_DONE;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [1:0]     state;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;
    logic           we_q;
    logic [NCH-1:0] sel_q;
    logic [DW-1:0]  rdata_q;
    logic           err_q;
    logic [CW-1:0]  cnt;

    logic [NCH-1:0] dec_sel;
    logic           dec_hit;
    logic           req_active;

`ifdef MEM_BUS_BRIDGE_POSTED_WRITE_EN
    // Set while the current transaction is a posted store that the core
    // has already retired.
    logic           posted_q;
`endif

    mem_bus_decode #(
        .AW          (AW),
        .NCH         (NCH),
        .REGION_BASE (REGION_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_decode (
        .addr (core_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
`ifdef MEM_BUS_BRIDGE_POSTED_WRITE_EN
            posted_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (core_req) begin
                        addr_q  <= core_addr;
                        wdata_q <= core_wdata;
                        we_q    <= core_we;
                        sel_q   <= dec_sel;
                        rdata_q <= '0;
                        cnt     <= '0;
                        // Unmapped addresses skip the bus entirely.
                        err_q   <= !dec_hit;
                        state   <= dec_hit ? ST_REQ : ST_DONE;
`ifdef MEM_BUS_BRIDGE_POSTED_WRITE_EN
                        posted_q <= core_we;
`endif
                    end
                end
                ST_REQ: begin
                    // A ready in the last allowed cycle still counts as success.
                    if (bus.ready) begin
                        if (!we_q) begin
                            rdata_q <= bus.rdata;
                        end
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        err_q <= 1'b1;
                        cnt   <= '0;
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_active = (state == ST_REQ);

    assign bus.valid = req_active;
    assign bus.sel   = req_active ? sel_q : '0;
    assign bus.we    = req_active & we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

    always_comb begin
        core_stall = 1'b0;
        core_rdata = '0;
        core_err   = 1'b0;
        case (state)
            ST_IDLE: core_stall = core_req;
            ST_REQ:  core_stall = 1'b1;
            ST_DONE: begin
                core_rdata = err_q ? ERR_DATA : rdata_q;
                core_err   = err_q;
            end
            default: core_stall = 1'b0;
        endcase
`ifdef MEM_BUS_BRIDGE_POSTED_WRITE_EN
        // Stores retire immediately; anything arriving while a posted
        // store drains waits, which keeps reads behind earlier writes.
        if (state == ST_IDLE) begin
            core_stall = core_req & ~core_we;
        end else if (posted_q) begin
            core_stall = core_req;
            core_rdata = '0;
        end
`endif
    end

endmodule

// File: tb/tb_mem_bus_bridge.sv
module tb_mem_bus_bridge;

    localparam int          AW      = 32;
    localparam int          DW      = 32;
    localparam int          NCH     = 2;
    localparam int          TIMEOUT = 16;
    localparam logic [31:0] ERRD    = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req;
    logic        core_we;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_stall;
    logic        core_err;

    always #5 clk = ~clk;

    mem_bus_bridge_if #(.AW(AW), .DW(DW), .NCH(NCH)) bus ();

    mem_bus_bridge #(
        .AW          (AW),
        .DW          (DW),
        .NCH         (NCH),
        .REGION_BASE ({32'h0000_1000, 32'h0000_0000}),
        .REGION_MASK ({32'hFFFF_F000, 32'hFFFF_F000}),
        .TIMEOUT     (TIMEOUT),
        .ERR_DATA    (ERRD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .core_err   (core_err),
        .bus        (bus)
    );

    // Per-cycle expectations, written by the stimulus, read by the checker.
    logic        chk_en = 1'b0;
    logic        e_first, e_last, e_stall, e_valid, e_we, e_err, chk_rd, chk_regs;
    logic [1:0]  e_sel;
    logic [31:0] e_addr, e_wdata, e_rdata;

    // Hand-computed whole-transaction expectations for directed cases.
    logic        pin_en = 1'b0;
    int          pin_stall, pin_valid, pin_errs;
    logic [1:0]  pin_sel;
    logic [31:0] pin_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    int          obs_stall, obs_valid, obs_errs;
    logic [1:0]  obs_sel;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (e_first) begin
                obs_stall = 0;
                obs_valid = 0;
                obs_errs  = 0;
                obs_sel   = 2'b00;
            end
            chk("core_stall", 32'(core_stall), 32'(e_stall));
            chk("bus_valid",  32'(bus.valid),  32'(e_valid));
            chk("bus_sel",    32'(bus.sel),    32'(e_sel));
            chk("core_err",   32'(core_err),   32'(e_err));
            if (e_valid) begin
                chk("bus_addr", bus.addr,      e_addr);
                chk("bus_we",   32'(bus.we),   32'(e_we));
                if (e_we) chk("bus_wdata", bus.wdata, e_wdata);
            end
            if (chk_rd) chk("core_rdata", core_rdata, e_rdata);
            if (chk_regs) begin
                chk("reset_bus_we",    32'(bus.we), 32'h0);
                chk("reset_bus_addr",  bus.addr,    32'h0);
                chk("reset_bus_wdata", bus.wdata,   32'h0);
            end
            obs_stall += int'(core_stall);
            obs_valid += int'(bus.valid);
            obs_errs  += int'(core_err);
            obs_sel    = obs_sel | bus.sel;
            if (e_last && pin_en) begin
                chk("pin_stall_cycles", obs_stall,  pin_stall);
                chk("pin_valid_cycles", obs_valid,  pin_valid);
                chk("pin_sel",          32'(obs_sel), 32'(pin_sel));
                chk("pin_err_pulses",   obs_errs,   pin_errs);
                chk("pin_rdata",        core_rdata, pin_rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_exp();
        e_first  = 1'b0;
        e_last   = 1'b0;
        e_stall  = 1'b0;
        e_valid  = 1'b0;
        e_we     = 1'b0;
        e_err    = 1'b0;
        e_sel    = 2'b00;
        chk_rd   = 1'b0;
        chk_regs = 1'b0;
    endtask

    // Address map: 0x0000_0xxx -> channel 0, 0x0000_1xxx -> channel 1.
    function automatic int decode_ch(input logic [31:0] a);
        if ((a & 32'hFFFF_F000) == 32'h0000_0000) return 0;
        if ((a & 32'hFFFF_F000) == 32'h0000_1000) return 1;
        return -1;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            core_req   = 1'b0;
            core_we    = 1'($urandom);
            core_addr  = $urandom;
            core_wdata = $urandom;
            bus.ready  = 1'($urandom);
            bus.rdata  = $urandom;
            clear_exp();
            tick();
        end
    endtask

    // One core access; the slave answers after `waits` wait states.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rd);
        int          ch, v, l;
        logic        err;
        logic [31:0] fin;
        ch = decode_ch(addr);
        if (ch < 0) begin
            v = 0; l = 1; err = 1'b1;
        end else if (waits < TIMEOUT) begin
            v = waits + 1; l = waits + 2; err = 1'b0;
        end else begin
            v = TIMEOUT; l = TIMEOUT + 1; err = 1'b1;
        end
        fin = err ? ERRD : (we ? 32'h0 : rd);
        for (int k = 0; k <= l; k++) begin
            core_req   = 1'b1;
            core_we    = we;
            core_addr  = addr;
            core_wdata = wdata;
            if (k >= 1 && k <= v) bus.ready = !err && (k == v);
            else                  bus.ready = 1'($urandom);
            bus.rdata = (bus.ready && k == v) ? rd : $urandom;
            e_first  = (k == 0);
            e_last   = (k == l);
            e_stall  = (k < l);
            e_valid  = (k >= 1 && k <= v);
            e_sel    = e_valid ? ((ch == 1) ? 2'b10 : 2'b01) : 2'b00;
            e_we     = we;
            e_addr   = addr;
            e_wdata  = wdata;
            e_err    = (k == l) && err;
            chk_rd   = (k == l);
            e_rdata  = fin;
            chk_regs = 1'b0;
            tick();
        end
    endtask

    task automatic pinned(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] rd,
                          input int p_stall, input int p_valid, input logic [1:0] p_sel,
                          input int p_errs, input logic [31:0] p_rdata);
        pin_stall = p_stall;
        pin_valid = p_valid;
        pin_sel   = p_sel;
        pin_errs  = p_errs;
        pin_rdata = p_rdata;
        pin_en    = 1'b1;
        access(we, addr, wdata, waits, rd);
        pin_en    = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          r, w, waits;

        rst        = 1'b1;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        bus.ready  = 1'b0;
        bus.rdata  = 32'h0;
        clear_exp();
        e_rdata = 32'h0;
        tick();

        // Reset state, then core_stall follows core_req combinationally.
        chk_en   = 1'b1;
        chk_rd   = 1'b1;
        chk_regs = 1'b1;
        tick();
        core_req = 1'b1;
        e_stall  = 1'b1;
        tick();
        rst = 1'b0;
        idle(2);

        // Directed cases with literal expectations.
        pinned(1'b0, 32'h0000_1004, 32'h0, 0, 32'h1234_5678, 2, 1, 2'b10, 0, 32'h1234_5678);
        pinned(1'b1, 32'h0000_0010, 32'hCAFE_F00D, 3, 32'h0, 5, 4, 2'b01, 0, 32'h0);
        pinned(1'b0, 32'h0000_5000, 32'h0, 0, 32'h0, 1, 0, 2'b00, 1, 32'hDEAD_BEEF);
        idle(1);
        pinned(1'b0, 32'h0000_1008, 32'h0, 1000, 32'h0, 17, 16, 2'b10, 1, 32'hDEAD_BEEF);
        pinned(1'b0, 32'h0000_0FFC, 32'h0, 15, 32'hA5A5_0F0F, 17, 16, 2'b01, 0, 32'hA5A5_0F0F);
        pinned(1'b1, 32'h0000_2000, 32'h1111_2222, 0, 32'h0, 1, 0, 2'b00, 1, 32'hDEAD_BEEF);
        pinned(1'b1, 32'h0000_1FFC, 32'h3333_4444, 15, 32'h0, 17, 16, 2'b10, 0, 32'h0);
        idle(2);

        // Reset during the second REQ cycle abandons the transaction.
        for (int k = 0; k < 3; k++) begin
            core_req   = 1'b1;
            core_we    = 1'b0;
            core_addr  = 32'h0000_1020;
            core_wdata = 32'h0;
            bus.ready  = (k == 0) ? 1'b1 : 1'b0;
            bus.rdata  = $urandom;
            rst        = (k == 2);
            clear_exp();
            e_first = (k == 0);
            e_stall = 1'b1;
            e_valid = (k >= 1);
            e_sel   = (k >= 1) ? 2'b10 : 2'b00;
            e_addr  = 32'h0000_1020;
            tick();
        end
        rst      = 1'b0;
        core_req = 1'b0;
        bus.ready = 1'b1;
        clear_exp();
        chk_rd  = 1'b1;
        e_rdata = 32'h0;
        tick();
        pinned(1'b0, 32'h0000_1020, 32'h0, 1, 32'h0BAD_F00D, 3, 2, 2'b10, 0, 32'h0BAD_F00D);

        // Randomized traffic, mostly back-to-back.
        for (int t = 0; t < 250; t++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            if (r < 4)      a[31:12] = 20'h00000;
            else if (r < 8) a[31:12] = 20'h00001;
            w = $urandom_range(0, 9);
            if (w < 7)      waits = $urandom_range(0, 3);
            else if (w < 8) waits = TIMEOUT - 1;
            else if (w < 9) waits = TIMEOUT;
            else            waits = $urandom_range(0, 6);
            access(1'($urandom), a, $urandom, waits, $urandom);
            idle($urandom_range(0, 2));
        end

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
